// File: rtl/rs232_rx.sv
// RS-232 style UART receiver: oversampled start/data/parity/stop framing with error flags.
// Define RS232_RX_SYNC_EN to pass rx_i through a two-flop synchronizer before sampling.
module rs232_rx #(
    parameter int OVS = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       rx_i,
    input  logic       psel_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       perr_o,
    output logic       ferr_o,
    output logic       busy_o
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          psel_r;
    logic          perr_r;
    logic          stop_r;
    logic          done_r;
    logic          armed;
    logic          rx_s;
    logic          line_ok;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

`ifdef RS232_RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] fill_q;

    // fill_q masks the reset value of the synchronizer so it cannot arm start detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            fill_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    assign rx_s    = sync_q[1];
    assign line_ok = fill_q[1];
`else
    assign rx_s    = rx_i;
    assign line_ok = 1'b1;
`endif

    // armed: a high line has been seen since reset or since a low stop bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            psel_r   <= 1'b0;
            perr_r   <= 1'b0;
            stop_r   <= 1'b0;
            done_r   <= 1'b0;
            armed    <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (tick_i) begin
                        if (!rx_s && armed) begin
                            state   <= START;
                            busy_o  <= 1'b1;
                            psel_r  <= psel_i;
                            bit_idx <= '0;
                            perr_r  <= 1'b0;
                        end else if (rx_s && line_ok) begin
                            armed <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (tick_i) begin
                        if (tick_cnt == CNT_HALF) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                                armed  <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick_i) begin
                        if (tick_cnt == CNT_FULL) begin
                            tick_cnt       <= '0;
                            shreg[bit_idx] <= rx_s;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= psel_r ? PARITY : STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_i) begin
                        if (tick_cnt == CNT_FULL) begin
                            tick_cnt <= '0;
                            perr_r   <= rx_s ^ even_par(shreg);
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick_i) begin
                        if (tick_cnt == CNT_FULL) begin
                            tick_cnt <= '0;
                            stop_r   <= rx_s;
                            done_r   <= 1'b1;
                            armed    <= rx_s;
                            state    <= IDLE;
                            busy_o   <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // result stage: one clock after the stop sample
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o  <= 8'h00;
            valid_o <= 1'b0;
            perr_o  <= 1'b0;
            ferr_o  <= 1'b0;
        end else begin
            valid_o <= done_r;
            if (done_r) begin
                data_o <= shreg;
                perr_o <= perr_r;
                ferr_o <= ~stop_r;
            end
        end
    end

endmodule
